// File: rtl/mem_access_stage_pkg.sv
// Shared types, default timeout and store-lane helpers for the memory stage.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;

    // Longest wait in BUSY before an access fault is reported.
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    // Bytes are always aligned; halves need addr[0]=0; words (and the
    // unused 2'b11 encoding) need addr[1:0]=0.
    function automatic logic is_misaligned(mem_size_t size, logic [1:0] off);
        case (size)
            MEM_BYTE: is_misaligned = 1'b0;
            MEM_HALF: is_misaligned = off[0];
            default:  is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(mem_size_t size, logic [1:0] off);
        case (size)
            MEM_BYTE: store_be = 4'b0001 << off;
            MEM_HALF: store_be = off[1] ? 4'b1100 : 4'b0011;
            default:  store_be = 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes; byte enables pick the lane.
    function automatic logic [31:0] store_wdata(mem_size_t size, logic [31:0] sd);
        case (size)
            MEM_BYTE: store_wdata = {4{sd[7:0]}};
            MEM_HALF: store_wdata = {2{sd[15:0]}};
            default:  store_wdata = sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the memory stage and the data memory.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ready, rdata);
    modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load-data lane select and sign/zero extension; purely combinational.
module mem_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[8*offset +: 8];
    assign lane_h = rdata[16*offset[1] +: 16];

    // Extend the selected lane; words pass through untouched.
    always_comb begin
        data = rdata;
        case (size)
            MEM_BYTE: data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
            MEM_HALF: data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues data-memory requests with timeout, aligns loads and
// registers the write-back bundle (wb_data also feeds mem_forward_data).
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic        reg_write_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_data,
    input  logic [31:0] store_data,
    mem_access_stage_if.master dmem,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        access_fault
);

    // Counter value seen in the last BUSY cycle allowed before the fault.
    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t  state, state_next;
    logic [7:0]  count;
    mem_size_t   size_in, size_q;
    logic        mem_op, addr_bad, accept, done, timeout;
    logic        we_q, unsigned_q, reg_write_q;
    logic [4:0]  rd_q;
    logic [31:0] addr_q, wdata_q, load_data;
    logic [3:0]  be_q;

    assign size_in  = mem_size_t'(mem_size);
    assign mem_op   = mem_read | mem_write;
    assign addr_bad = is_misaligned(size_in, alu_data[1:0]);
    assign accept   = (state == MEM_IDLE) & in_valid & mem_op & ~addr_bad;
    assign done     = (state == MEM_BUSY) & dmem.ready;
    assign timeout  = (state == MEM_BUSY) & ~dmem.ready & (count == COUNT_LAST);

    mem_load_align u_align (
        .rdata       (dmem.rdata),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= MEM_IDLE;
        else       state <= state_next;
    end

    // Next state: enter BUSY on an accepted access, leave on ready or timeout.
    always_comb begin
        state_next = state;
        case (state)
            MEM_IDLE: if (accept)          state_next = MEM_BUSY;
            MEM_BUSY: if (done || timeout) state_next = MEM_IDLE;
            default:                       state_next = MEM_IDLE;
        endcase
    end

    // Outputs: request held for all of BUSY from captured registers; stall
    // releases on ready or in the timeout cycle so upstream can move on.
    always_comb begin
        dmem.req   = (state == MEM_BUSY);
        dmem.we    = we_q;
        dmem.addr  = {addr_q[31:2], 2'b00};
        dmem.wdata = wdata_q;
        dmem.be    = be_q;
        stall      = 1'b0;
        if (!reset) begin
            case (state)
                MEM_IDLE: stall = accept;
                MEM_BUSY: stall = ~dmem.ready & ~timeout;
                default:  stall = 1'b0;
            endcase
        end
    end

    // BUSY cycle counter; cleared whenever the FSM is idle or finishing.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if ((state == MEM_BUSY) && !done && !timeout)
            count <= count + 8'd1;
        else
            count <= '0;
    end

    // Capture the access on acceptance; held stable throughout BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            size_q      <= MEM_BYTE;
            unsigned_q  <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (accept) begin
            we_q        <= mem_write;
            addr_q      <= alu_data;
            wdata_q     <= store_wdata(size_in, store_data);
            be_q        <= store_be(size_in, alu_data[1:0]);
            size_q      <= size_in;
            unsigned_q  <= mem_unsigned;
            rd_q        <= rd_in;
            reg_write_q <= reg_write_in;
        end
    end

    // Write-back bundle: retire pass-through/misaligned ops from IDLE,
    // completed or timed-out accesses from BUSY; pulses clear otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
            if (state == MEM_IDLE) begin
                if (in_valid && (!mem_op || addr_bad)) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= rd_in;
                    wb_data      <= alu_data;
                    wb_reg_write <= reg_write_in & ~mem_op;
                    misaligned   <= mem_op;
                end
            end else if (done) begin
                wb_valid     <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= reg_write_q & ~we_q;
                if (!we_q) wb_data <= load_data;
            end else if (timeout) begin
                wb_valid     <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= 1'b0;
                access_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a delay-programmable memory.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, mem_read, mem_write, mem_unsigned, reg_write_in;
    logic [1:0]  mem_size;
    logic [4:0]  rd_in;
    logic [31:0] alu_data, store_data;
    logic        stall, wb_valid, wb_reg_write, misaligned, access_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mem_access_stage_if dmem();

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .reg_write_in(reg_write_in), .rd_in(rd_in), .alu_data(alu_data),
        .store_data(store_data), .dmem(dmem), .stall(stall), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned), .access_fault(access_fault)
    );

    // Memory model: ready in the (ready_delay+1)-th cycle of a request.
    int          ready_delay = 0;
    bit          ready_force = 0;
    logic [31:0] mem_rdata = '0;
    int          busy_n = 0;
    always @(posedge clk) begin
        if (dmem.req && !dmem.ready) busy_n <= busy_n + 1;
        else                         busy_n <= 0;
    end
    assign dmem.ready = ready_force | (dmem.req && (busy_n == ready_delay));
    assign dmem.rdata = mem_rdata;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        af;
    } wb_t;
    typedef struct packed { wb_t w; wb_t m; } sb_t;

    localparam wb_t M_ALL   = '{rw:1'b1, rd:5'h1f, data:32'hffff_ffff, mis:1'b1, af:1'b1};
    localparam wb_t M_FLAGS = '{rw:1'b1, rd:5'h00, data:32'h0, mis:1'b1, af:1'b1};
    localparam wb_t M_MIS   = '{rw:1'b1, rd:5'h00, data:32'hffff_ffff, mis:1'b1, af:1'b1};

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    // Drive one op, hold it while stalled, observe until wb_valid (bounded).
    // Starts and ends one time unit after a rising edge.
    task automatic run_op(input logic rd_, input logic wr_, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] rd, input logic rw,
                          output int stalls, output int reqs, output int edges,
                          output bit got, output wb_t obs,
                          output logic [31:0] b_addr, output logic [31:0] b_wdata,
                          output logic [3:0] b_be, output logic b_we,
                          output bit stable, output logic req_at_wb);
        logic st;
        stalls = 0; reqs = 0; edges = 0; got = 0; obs = '0; stable = 1;
        b_addr = '0; b_wdata = '0; b_be = '0; b_we = 1'b0; req_at_wb = 1'b0;
        in_valid = 1'b1; mem_read = rd_; mem_write = wr_; mem_size = sz;
        mem_unsigned = uns; alu_data = addr; store_data = sd; rd_in = rd;
        reg_write_in = rw;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dmem.req) begin
                if (reqs == 0) begin
                    b_addr = dmem.addr; b_wdata = dmem.wdata; b_be = dmem.be; b_we = dmem.we;
                end else if ({dmem.addr, dmem.wdata, dmem.be, dmem.we} !== {b_addr, b_wdata, b_be, b_we})
                    stable = 0;
                reqs++;
            end
            if (stall) stalls++;
            if (wb_valid) begin
                got = 1;
                obs = {wb_reg_write, wb_rd, wb_data, misaligned, access_fault};
                req_at_wb = dmem.req;
                break;
            end
            st = stall;
            @(posedge clk); #1; edges++;
            if (!st) begin in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; end
        end
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_size = 2'b00; mem_unsigned = 1'b0; reg_write_in = 1'b0; rd_in = '0;
        alu_data = '0; store_data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.be, stall, wb_valid,
             wb_reg_write, wb_rd, wb_data, misaligned, access_fault} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b wbv=%b wbd=%h addr=%h stall=%b exp all zero",
                     dmem.req, wb_valid, wb_data, dmem.addr, stall);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        int s, r, e; bit g, stb; wb_t o; logic [31:0] ba, bw; logic [3:0] bb; logic bwe, rq;
        sb_t x;
        sb_q.push_back('{w:'{rw:1'b1, rd:5'd5, data:32'h0000_1234, mis:1'b0, af:1'b0}, m:M_ALL});
        run_op(1'b0, 1'b0, MEM_WORD, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1,
               s, r, e, g, o, ba, bw, bb, bwe, stb, rq);
        x = sb_q.pop_front();
        checks++;
        if (!g || ((o & x.m) !== (x.w & x.m))) begin
            errors++; $display("FAIL alu_wb got %h (seen=%0d) exp %h", o, g, x.w);
        end
        checks++;
        if ({s, r, e} !== {32'd0, 32'd0, 32'd1}) begin
            errors++; $display("FAIL alu_timing got stalls=%0d reqs=%0d lat=%0d exp 0 0 1", s, r, e);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL alu_wb_idle got wb_valid=%b exp 0", wb_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        sb_t x; wb_t o;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_size = MEM_WORD;
                alu_data = 32'hA000_0000 + 32'(c); rd_in = 5'(10 + c); reg_write_in = c[0];
                sb_q.push_back('{w:'{rw:c[0], rd:5'(10 + c), data:32'hA000_0000 + 32'(c),
                                   mis:1'b0, af:1'b0}, m:M_ALL});
            end else in_valid = 1'b0;
            @(negedge clk);
            if (c > 0) begin
                x = sb_q.pop_front();
                o = {wb_reg_write, wb_rd, wb_data, misaligned, access_fault};
                checks++;
                if (wb_valid !== 1'b1 || stall !== 1'b0 || ((o & x.m) !== (x.w & x.m))) begin
                    errors++;
                    $display("FAIL b2b_wb[%0d] got v=%b st=%b %h exp v=1 st=0 %h", c - 1, wb_valid, stall, o, x.w);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_idle_ready();
        ready_force = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({dmem.req, stall, wb_valid} !== 3'b000) begin
                errors++;
                $display("FAIL idle_ready got req=%b stall=%b wbv=%b exp 0 0 0", dmem.req, stall, wb_valid);
            end
            @(posedge clk); #1;
        end
        ready_force = 0;
    endtask

    task automatic test_store_word();
        int s, r, e; bit g, stb; wb_t o; logic [31:0] ba, bw; logic [3:0] bb; logic bwe, rq;
        sb_t x;
        ready_delay = 3;
        sb_q.push_back('{w:'{rw:1'b0, rd:5'd0, data:32'h0, mis:1'b0, af:1'b0}, m:M_FLAGS});
        run_op(1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd9, 1'b1,
               s, r, e, g, o, ba, bw, bb, bwe, stb, rq);
        x = sb_q.pop_front();
        checks++;
        if (!g || ((o & x.m) !== (x.w & x.m))) begin
            errors++; $display("FAIL sw_wb got %h (seen=%0d) exp %h", o, g, x.w);
        end
        checks++;
        if ({bb, ba, bw, bwe} !== {4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL sw_bus got be=%b addr=%h wdata=%h we=%b exp 1111 00000100 deadbeef 1", bb, ba, bw, bwe);
        end
        checks++;
        if ({s, r, e} !== {32'd4, 32'd4, 32'd5} || !stb || rq !== 1'b0) begin
            errors++;
            $display("FAIL sw_timing got stalls=%0d reqs=%0d lat=%0d stable=%0d req_end=%b exp 4 4 5 1 0",
                     s, r, e, stb, rq);
        end
    endtask

    task automatic test_store_lanes();
        int s, r, e; bit g, stb; wb_t o; logic [31:0] ba, bw; logic [3:0] bb; logic bwe, rq;
        sb_t x;
        logic [101:0] t [5];   // {size, addr, sd, be, wdata}
        ready_delay = 0;
        t[0] = {MEM_BYTE, 32'h0000_0101, 32'h1234_5678, 4'b0010, 32'h7878_7878};
        t[1] = {MEM_BYTE, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5};
        t[2] = {MEM_HALF, 32'h0000_0102, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD};
        t[3] = {MEM_HALF, 32'h0000_0100, 32'h0000_1357, 4'b0011, 32'h1357_1357};
        t[4] = {MEM_WORD, 32'h0000_0204, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D};
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{w:'{rw:1'b0, rd:5'd0, data:32'h0, mis:1'b0, af:1'b0}, m:M_FLAGS});
            run_op(1'b0, 1'b1, t[i][101:100], 1'b0, t[i][99:68], t[i][67:36], 5'd3, 1'b1,
                   s, r, e, g, o, ba, bw, bb, bwe, stb, rq);
            x = sb_q.pop_front();
            checks++;
            if (!g || ((o & x.m) !== (x.w & x.m)) || e != 2) begin
                errors++; $display("FAIL store_lane_wb[%0d] got %h lat=%0d exp %h lat=2", i, o, e, x.w);
            end
            checks++;
            if ({bb, bw, ba, bwe} !== {t[i][35:0], t[i][99:70], 2'b00, 1'b1}) begin
                errors++;
                $display("FAIL store_lane_bus[%0d] got be=%b wdata=%h addr=%h exp be=%b wdata=%h",
                         i, bb, bw, ba, t[i][35:32], t[i][31:0]);
            end
        end
    endtask

    task automatic test_loads();
        int s, r, e; bit g, stb; wb_t o; logic [31:0] ba, bw; logic [3:0] bb; logic bwe, rq;
        sb_t x;
        logic [98:0] t [9];    // {size, unsigned, addr, rdata, expected}
        ready_delay = 1;
        t[0] = {MEM_BYTE, 1'b0, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80};
        t[1] = {MEM_BYTE, 1'b1, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080};
        t[2] = {MEM_BYTE, 1'b0, 32'h0000_0100, 32'h1234_567F, 32'h0000_007F};
        t[3] = {MEM_BYTE, 1'b0, 32'h0000_0101, 32'h0000_C3FF, 32'hFFFF_FFC3};
        t[4] = {MEM_HALF, 1'b0, 32'h0000_0102, 32'h80FF_0000, 32'hFFFF_80FF};
        t[5] = {MEM_HALF, 1'b1, 32'h0000_0102, 32'h80FF_0000, 32'h0000_80FF};
        t[6] = {MEM_HALF, 1'b0, 32'h0000_0100, 32'h0000_7FFE, 32'h0000_7FFE};
        t[7] = {MEM_WORD, 1'b0, 32'h0000_0104, 32'h89AB_CDEF, 32'h89AB_CDEF};
        t[8] = {MEM_WORD, 1'b1, 32'h0000_0104, 32'h89AB_CDEF, 32'h89AB_CDEF};
        for (int i = 0; i < 9; i++) begin
            mem_rdata = t[i][63:32];
            sb_q.push_back('{w:'{rw:1'b1, rd:5'(i + 1), data:t[i][31:0], mis:1'b0, af:1'b0}, m:M_ALL});
            run_op(1'b1, 1'b0, t[i][98:97], t[i][96], t[i][95:64], 32'h0, 5'(i + 1), 1'b1,
                   s, r, e, g, o, ba, bw, bb, bwe, stb, rq);
            x = sb_q.pop_front();
            checks++;
            if (!g || ((o & x.m) !== (x.w & x.m))) begin
                errors++; $display("FAIL load_wb[%0d] got %h (seen=%0d) exp %h", i, o, g, x.w);
            end
            checks++;
            if ({ba, bwe} !== {t[i][95:66], 2'b00, 1'b0} || {s, e} !== {32'd2, 32'd3}) begin
                errors++;
                $display("FAIL load_bus[%0d] got addr=%h we=%b stalls=%0d lat=%0d exp addr=%h we=0 2 3",
                         i, ba, bwe, s, e, {t[i][95:66], 2'b00});
            end
        end
    endtask

    task automatic test_misaligned();
        int s, r, e; bit g, stb; wb_t o; logic [31:0] ba, bw; logic [3:0] bb; logic bwe, rq;
        sb_t x;
        logic [35:0] t [4];    // {size, read, write, addr}
        t[0] = {MEM_WORD, 1'b1, 1'b0, 32'h0000_0101};
        t[1] = {MEM_HALF, 1'b0, 1'b1, 32'h0000_0103};
        t[2] = {MEM_HALF, 1'b1, 1'b0, 32'h0000_0101};
        t[3] = {MEM_WORD, 1'b0, 1'b1, 32'h0000_0102};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{w:'{rw:1'b0, rd:5'd0, data:t[i][31:0], mis:1'b1, af:1'b0}, m:M_MIS});
            run_op(t[i][33], t[i][32], t[i][35:34], 1'b0, t[i][31:0], 32'h5555_5555, 5'd4, 1'b1,
                   s, r, e, g, o, ba, bw, bb, bwe, stb, rq);
            x = sb_q.pop_front();
            checks++;
            if (!g || ((o & x.m) !== (x.w & x.m))) begin
                errors++; $display("FAIL misaligned_wb[%0d] got %h (seen=%0d) exp %h", i, o, g, x.w);
            end
            checks++;
            if ({s, r, e} !== {32'd0, 32'd0, 32'd1}) begin
                errors++;
                $display("FAIL misaligned_timing[%0d] got stalls=%0d reqs=%0d lat=%0d exp 0 0 1", i, s, r, e);
            end
            @(negedge clk);
            checks++;
            if ({misaligned, wb_valid} !== 2'b00) begin
                errors++; $display("FAIL misaligned_pulse[%0d] got mis=%b wbv=%b exp 0 0", i, misaligned, wb_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        int s, r, e; bit g, stb; wb_t o; logic [31:0] ba, bw; logic [3:0] bb; logic bwe, rq;
        sb_t x;
        ready_delay = 1000;
        sb_q.push_back('{w:'{rw:1'b0, rd:5'd0, data:32'h0, mis:1'b0, af:1'b1}, m:M_FLAGS});
        run_op(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0000_0200, 32'h0, 5'd6, 1'b1,
               s, r, e, g, o, ba, bw, bb, bwe, stb, rq);
        x = sb_q.pop_front();
        checks++;
        if (!g || ((o & x.m) !== (x.w & x.m))) begin
            errors++; $display("FAIL timeout_wb got %h (seen=%0d) exp %h", o, g, x.w);
        end
        checks++;
        if ({s, r, e} !== {32'd4, 32'd4, 32'd5} || rq !== 1'b0) begin
            errors++;
            $display("FAIL timeout_timing got stalls=%0d reqs=%0d lat=%0d req_end=%b exp 4 4 5 0", s, r, e, rq);
        end
        @(negedge clk);
        checks++;
        if ({access_fault, wb_valid, dmem.req} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_pulse got af=%b wbv=%b req=%b exp 0 0 0", access_fault, wb_valid, dmem.req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy();
        ready_delay = 1000;
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = MEM_WORD;
        alu_data = 32'h0000_0300; rd_in = 5'd8; reg_write_in = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({dmem.req, stall} !== 2'b11) begin
            errors++; $display("FAIL rst_busy_pre got req=%b stall=%b exp 1 1", dmem.req, stall);
        end
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.be, stall, wb_valid,
             wb_reg_write, wb_rd, wb_data, misaligned, access_fault} !== '0) begin
            errors++;
            $display("FAIL rst_busy_outputs got req=%b addr=%h wbv=%b stall=%b exp all zero",
                     dmem.req, dmem.addr, wb_valid, stall);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dmem.req, wb_valid} !== 2'b00) begin
            errors++; $display("FAIL rst_busy_abandon got req=%b wbv=%b exp 0 0", dmem.req, wb_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_idle_ready();
        test_store_word();
        test_store_lanes();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion exp finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
